// File: rtl/fpu_mul_arb_pkg.sv
// Shared types and constants for the two-requester double-precision multiplier arbiter.
package fpu_mul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

  // Every registered bit of the arbiter except the timeout counter, whose width is a parameter.
  typedef struct packed {
    state_e      state;
    logic        prio;
    logic        owner;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] res;
    logic        illegal;
    logic        overflow;
    logic [1:0]  gnt;
    logic [1:0]  valid;
    logic        timeout;
    logic        mul_ena;
  } arb_reg_t;

  localparam arb_reg_t ARB_RST = '{
    state:    ST_IDLE,
    prio:     1'b0,
    owner:    1'b0,
    mul_a:    '0,
    mul_b:    '0,
    res:      '0,
    illegal:  1'b0,
    overflow: 1'b0,
    gnt:      '0,
    valid:    '0,
    timeout:  1'b0,
    mul_ena:  1'b0
  };

endpackage

// File: rtl/fpu_mul_arb.sv
// Round-robin arbiter sharing one external double-precision multiplier between two requesters,
// with a watchdog that aborts a hung multiply and returns the canonical NaN.
module fpu_mul_arb #(
  parameter int TIMEOUT = 63
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [1:0]  i_req,
  input  logic [63:0] i_a0,
  input  logic [63:0] i_b0,
  input  logic [63:0] i_a1,
  input  logic [63:0] i_b1,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_valid,
  output logic [63:0] o_res,
  output logic        o_illegal_op,
  output logic        o_overflow,
  output logic        o_timeout,
  output logic        o_mul_ena,
  output logic [63:0] o_mul_a,
  output logic [63:0] o_mul_b,
  input  logic [63:0] i_mul_res,
  input  logic        i_mul_illegal_op,
  input  logic        i_mul_overflow,
  input  logic        i_mul_valid,
  input  logic        i_mul_busy
);
  import fpu_mul_arb_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_reg_t         r_q;
  arb_reg_t         w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_win;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    w_nxt         = r_q;
    w_cnt_nxt     = r_cnt;
    w_win         = 1'b0;
    w_nxt.gnt     = '0;
    w_nxt.valid   = '0;
    w_nxt.timeout = 1'b0;
    w_nxt.mul_ena = 1'b0;

    case (r_q.state)
      ST_IDLE: begin
        if (|i_req && !i_mul_busy) begin
          // A lone request wins outright; a tie goes to the preferred requester.
          w_win       = (&i_req) ? r_q.prio : i_req[1];
          w_nxt.state = ST_ISSUE;
          w_nxt.owner = w_win;
          w_nxt.prio  = ~w_win;
          w_nxt.gnt   = w_win ? 2'b10 : 2'b01;
          w_nxt.mul_a = w_win ? i_a1 : i_a0;
          w_nxt.mul_b = w_win ? i_b1 : i_b0;
        end
      end
      ST_ISSUE: begin
        w_nxt.state   = ST_WAIT;
        w_nxt.mul_ena = 1'b1;
        w_cnt_nxt     = '0;
      end
      ST_WAIT: begin
        if (i_mul_valid) begin
          w_nxt.state    = ST_RESP;
          w_nxt.res      = i_mul_res;
          w_nxt.illegal  = i_mul_illegal_op;
          w_nxt.overflow = i_mul_overflow;
          w_nxt.valid    = r_q.owner ? 2'b10 : 2'b01;
        end else if (r_cnt >= CNT_W'(TIMEOUT)) begin
          w_nxt.state    = ST_RESP;
          w_nxt.res      = CANON_NAN;
          w_nxt.illegal  = 1'b1;
          w_nxt.overflow = 1'b0;
          w_nxt.timeout  = 1'b1;
          w_nxt.valid    = r_q.owner ? 2'b10 : 2'b01;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_nxt.state = ST_IDLE;
      end
      default: begin
        w_nxt     = ARB_RST;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      // NOTE: the operand and result registers are plain flops, not memories, so they reset with everything else.
      r_q   <= ARB_RST;
      r_cnt <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of statement order.
      r_q   <= w_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_gnt        = r_q.gnt;
  assign o_valid      = r_q.valid;
  assign o_res        = r_q.res;
  assign o_illegal_op = r_q.illegal;
  assign o_overflow   = r_q.overflow;
  assign o_timeout    = r_q.timeout;
  assign o_mul_ena    = r_q.mul_ena;
  assign o_mul_a      = r_q.mul_a;
  assign o_mul_b      = r_q.mul_b;

endmodule

// File: tb/tb_fpu_mul_arb.sv
// Self-checking bench for fpu_mul_arb: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a behavioural multiplier stub.
module tb_fpu_mul_arb;
  localparam int          TO      = 8;
  localparam logic [63:0] NAN_C   = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] INF_C   = 64'h7FF0_0000_0000_0000;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic [1:0]  i_req = '0;
  logic [63:0] i_a0 = '0, i_b0 = '0, i_a1 = '0, i_b1 = '0;
  logic [1:0]  o_gnt, o_valid;
  logic [63:0] o_res, o_mul_a, o_mul_b;
  logic        o_illegal_op, o_overflow, o_timeout, o_mul_ena;
  logic [63:0] i_mul_res = '0;
  logic        i_mul_illegal_op = 1'b0, i_mul_overflow = 1'b0;
  logic        i_mul_valid = 1'b0, i_mul_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Multiplier stub controls
  int stub_lat  = 2;
  bit stub_hang = 1'b0;
  bit stub_rand = 1'b0;
  bit inject    = 1'b0;
  bit s_active  = 1'b0;
  bit s_hang    = 1'b0;
  int s_remain  = 0;

  // Transaction-level model state
  int          m_e = 0, m_g = 0, m_next_ok = 0;
  bit          m_txn = 1'b0;
  logic        m_own = 1'b0, m_prio = 1'b0;
  logic [1:0]  m_gnt = '0, m_valid = '0;
  logic        m_to = 1'b0, m_ena = 1'b0, m_ill = 1'b0, m_ovf = 1'b0;
  logic [63:0] m_a = '0, m_b = '0, m_res = '0;

  fpu_mul_arb #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_req(i_req),
    .i_a0(i_a0), .i_b0(i_b0), .i_a1(i_a1), .i_b1(i_b1),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_res(o_res),
    .o_illegal_op(o_illegal_op), .o_overflow(o_overflow), .o_timeout(o_timeout),
    .o_mul_ena(o_mul_ena), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_res(i_mul_res), .i_mul_illegal_op(i_mul_illegal_op),
    .i_mul_overflow(i_mul_overflow), .i_mul_valid(i_mul_valid), .i_mul_busy(i_mul_busy)
  );

  initial forever #5 i_clk = ~i_clk;
  initial forever begin @(posedge i_clk); cyc++; end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic dmul(input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] r, output logic ill, output logic ovf);
    real p;
    p   = $bitstoreal(a) * $bitstoreal(b);
    r   = $realtobits(p);
    ill = (r[62:52] == 11'h7FF) && (r[51:0] != 52'd0);
    ovf = (r[62:52] == 11'h7FF) && (r[51:0] == 52'd0) &&
          (a[62:52] != 11'h7FF) && (b[62:52] != 11'h7FF);
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r[62:52] = 11'h7F0 + 11'($urandom_range(0, 14));
      1: r = NAN_C;
      2: r = 64'd0;
      3: r = INF_C;
      default: r[62:52] = 11'h3C0 + 11'($urandom_range(0, 128));
    endcase
    return r;
  endfunction

  // Multiplier stub: answers each start after a fixed or random latency, may hang, and
  // throws stray done pulses when idle so the arbiter's filtering gets exercised.
  initial begin
    logic [63:0] r;
    logic ill, ovf;
    forever begin
      @(posedge i_clk); #1;
      i_mul_valid = 1'b0;
      if (!i_nrst) s_active = 1'b0;
      if (o_mul_ena) begin
        s_active = 1'b1;
        s_remain = stub_rand ? int'($urandom_range(0, 5)) : stub_lat;
        s_hang   = stub_hang || (stub_rand && $urandom_range(0, 9) == 0);
      end
      if (inject) begin
        i_mul_valid = 1'b1;
        i_mul_res   = {$urandom, $urandom};
      end else if (s_active) begin
        if (!s_hang) begin
          if (s_remain == 0) begin
            dmul(o_mul_a, o_mul_b, r, ill, ovf);
            i_mul_valid = 1'b1; i_mul_res = r;
            i_mul_illegal_op = ill; i_mul_overflow = ovf;
            s_active = 1'b0;
          end else begin
            s_remain--;
          end
        end
      end else if (stub_rand && $urandom_range(0, 3) == 0) begin
        i_mul_valid = 1'b1;
        i_mul_res   = {$urandom, $urandom};
        i_mul_illegal_op = 1'($urandom); i_mul_overflow = 1'($urandom);
      end
    end
  end

  task automatic model_reset();
    m_txn = 1'b0; m_prio = 1'b0; m_own = 1'b0; m_next_ok = 0;
    m_gnt = '0; m_valid = '0; m_to = 1'b0; m_ena = 1'b0;
    m_ill = 1'b0; m_ovf = 1'b0; m_a = '0; m_b = '0; m_res = '0;
  endtask

  // One rising edge of the model: grant when free, start one edge later, finish on the
  // first done pulse from the second edge on, or at the watchdog deadline.
  task automatic model_step();
    m_e++;
    m_gnt = '0; m_valid = '0; m_to = 1'b0; m_ena = 1'b0;
    if (!m_txn) begin
      if (m_e >= m_next_ok && i_req != 2'b00 && !i_mul_busy) begin
        m_own  = (i_req == 2'b11) ? m_prio : i_req[1];
        m_prio = !m_own;
        m_txn  = 1'b1;
        m_g    = m_e;
        m_gnt  = m_own ? 2'b10 : 2'b01;
        m_a    = m_own ? i_a1 : i_a0;
        m_b    = m_own ? i_b1 : i_b0;
      end
    end else if (m_e == m_g + 1) begin
      m_ena = 1'b1;
    end else if (i_mul_valid || m_e == m_g + 2 + TO) begin
      if (i_mul_valid) begin
        m_res = i_mul_res; m_ill = i_mul_illegal_op; m_ovf = i_mul_overflow;
      end else begin
        m_res = NAN_C; m_ill = 1'b1; m_ovf = 1'b0; m_to = 1'b1;
      end
      m_valid   = m_own ? 2'b10 : 2'b01;
      m_txn     = 1'b0;
      m_next_ok = m_e + 2;
    end
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      if (i_nrst) model_step();
      @(negedge i_clk);
      if (!i_nrst) model_reset();
      check("o_gnt", 64'(o_gnt), 64'(m_gnt));
      check("o_valid", 64'(o_valid), 64'(m_valid));
      check("o_timeout", 64'(o_timeout), 64'(m_to));
      check("o_mul_ena", 64'(o_mul_ena), 64'(m_ena));
      check("o_res", o_res, m_res);
      check("o_illegal_op", 64'(o_illegal_op), 64'(m_ill));
      check("o_overflow", 64'(o_overflow), 64'(m_ovf));
      check("o_mul_a", o_mul_a, m_a);
      check("o_mul_b", o_mul_b, m_b);
    end
  end

  task automatic wait_gnt(output logic [1:0] g, output int t);
    g = '0; t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_gnt != 2'b00) begin g = o_gnt; t = cyc; return; end
    end
    n_tests++; n_fail++;
    $display("FAIL gnt_wait: o_gnt stayed 0 for 100 cycles, required a grant");
  endtask

  task automatic wait_valid(output logic [1:0] v, output int t);
    v = '0; t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_valid != 2'b00) begin v = o_valid; t = cyc; return; end
    end
    n_tests++; n_fail++;
    $display("FAIL valid_wait: o_valid stayed 0 for 100 cycles, required a result");
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1 i_nrst = 1'b0;
    @(posedge i_clk); #1 i_nrst = 1'b1;
  endtask

  initial begin
    logic [1:0] g, v;
    int tg, tv, tv_prev, cnt;

    repeat (2) @(negedge i_clk);
    check("rst_gnt", 64'(o_gnt), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_res", o_res, 64'd0);
    check("rst_mul_ena", 64'(o_mul_ena), 64'd0);
    @(posedge i_clk); #1 i_nrst = 1'b1;

    // Single request: 2.0 * 3.0
    i_a0 = 64'h4000_0000_0000_0000; i_b0 = 64'h4008_0000_0000_0000;
    stub_lat = 2; i_req = 2'b01;
    wait_gnt(g, tg); i_req = 2'b00;
    check("single_gnt", 64'(g), 64'd1);
    wait_valid(v, tv);
    check("single_valid", 64'(v), 64'd1);
    check("single_res", o_res, 64'h4018_0000_0000_0000);
    check("single_flags", {o_illegal_op, o_overflow}, 64'd0);
    check("single_latency", 64'(tv - tg), 64'd4);

    // Simultaneous requests after reset: requester 0 first, then 1 after one idle cycle
    do_reset();
    i_a1 = 64'h4010_0000_0000_0000; i_b1 = 64'h3FE0_0000_0000_0000;
    i_req = 2'b11;
    wait_gnt(g, tg); i_req[0] = 1'b0;
    check("tie_first_gnt", 64'(g), 64'd1);
    wait_valid(v, tv_prev);
    check("tie_first_valid", 64'(v), 64'd1);
    wait_gnt(g, tg); i_req[1] = 1'b0;
    check("tie_second_gnt", 64'(g), 64'd2);
    check("tie_gap", 64'(tg - tv_prev), 64'd2);
    wait_valid(v, tv);
    check("tie_second_valid", 64'(v), 64'd2);
    check("tie_second_res", o_res, 64'h4000_0000_0000_0000);

    // Fairness with both requests held
    do_reset();
    i_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, tg);
      check("fair_gnt", 64'(g), (k % 2 == 1) ? 64'd2 : 64'd1);
    end
    i_req = 2'b00;
    wait_valid(v, tv);

    // Watchdog abort
    stub_hang = 1'b1; i_req = 2'b01;
    wait_gnt(g, tg); i_req = 2'b00;
    wait_valid(v, tv);
    check("to_valid", 64'(v), 64'd1);
    check("to_latency", 64'(tv - tg), 64'd10);
    check("to_flag", 64'(o_timeout), 64'd1);
    check("to_res", o_res, NAN_C);
    check("to_flags", {o_illegal_op, o_overflow}, 64'd2);
    stub_hang = 1'b0;

    // Busy multiplier holds off grants
    @(negedge i_clk);
    i_mul_busy = 1'b1; i_req = 2'b01; cnt = 0;
    repeat (20) begin @(negedge i_clk); if (o_gnt != 2'b00) cnt++; end
    check("busy_no_gnt", 64'(cnt), 64'd0);
    i_mul_busy = 1'b0;
    wait_gnt(g, tg); i_req = 2'b00;
    check("busy_release_gnt", 64'(g), 64'd1);
    wait_valid(v, tv);

    // Overflow passthrough on requester 1
    i_a1 = 64'h7FE0_0000_0000_0000; i_b1 = 64'h7FE0_0000_0000_0000; i_req = 2'b10;
    wait_gnt(g, tg); i_req = 2'b00;
    check("ovf_gnt", 64'(g), 64'd2);
    wait_valid(v, tv);
    check("ovf_valid", 64'(v), 64'd2);
    check("ovf_res", o_res, INF_C);
    check("ovf_flags", {o_illegal_op, o_overflow}, 64'd1);

    // Reset during WAIT drops the transaction; a late done pulse is ignored
    stub_hang = 1'b1; i_req = 2'b01;
    wait_gnt(g, tg); i_req = 2'b00;
    repeat (3) @(negedge i_clk);
    @(posedge i_clk); #1 i_nrst = 1'b0;
    @(negedge i_clk);
    check("rstw_res", o_res, 64'd0);
    check("rstw_mul_a", o_mul_a, 64'd0);
    check("rstw_outs", {o_gnt, o_valid, o_timeout, o_mul_ena, o_illegal_op, o_overflow}, 64'd0);
    @(posedge i_clk); #1 i_nrst = 1'b1; stub_hang = 1'b0;
    @(negedge i_clk); inject = 1'b1;
    @(posedge i_clk); #2 inject = 1'b0;
    cnt = 0;
    repeat (12) begin @(negedge i_clk); if (o_valid != 2'b00) cnt++; end
    check("rstw_no_valid", 64'(cnt), 64'd0);

    // Randomized traffic, with one reset in the middle
    stub_rand = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      @(posedge i_clk); #1;
      if (it == 1500) i_nrst = 1'b0;
      if (it == 1502) i_nrst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (i_req[i] && o_gnt[i]) begin
          i_req[i] = 1'b0;
        end else if (!i_req[i] && $urandom_range(0, 2) == 0) begin
          i_req[i] = 1'b1;
          if (i == 0) begin i_a0 = rand_op(); i_b0 = rand_op(); end
          else        begin i_a1 = rand_op(); i_b1 = rand_op(); end
        end
      end
      i_mul_busy = ($urandom_range(0, 4) == 0);
    end
    stub_rand = 1'b0; i_req = 2'b00; i_mul_busy = 1'b0;
    repeat (40) @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
